daccess_axi_bridge: RTL and testbench

Converts the CPU core's single-outstanding data-access port (`daccess_*`) into AXI3 master read and write transactions on the top-level `ar*/r*/aw*/w*/b*` channels. The bridge sits between the core's data-access interface and the SoC AXI interconnect, replacing the tie-offs currently on `daccess_valid` and `daccess_wresp`. It handles one single-beat transfer at a time.

---
 rtl/daccess_axi_pkg.sv | 35 +++
 rtl/daccess_axi_bridge.sv | 199 +++++++++++++++++++
 tb/tb_daccess_axi_bridge.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/daccess_axi_pkg.sv
// Shared types, constants and helpers for the CPU data-access to AXI3 bridge.
package daccess_axi_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;
    localparam int unsigned ID_W   = 4;
    localparam int unsigned SIZE_W = 3;
    localparam int unsigned LEN_W  = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_REQ  = 3'd3,
        WR_RESP = 3'd4,
        DONE    = 3'd5
    } state_t;

    localparam logic [1:0]       AXI_BURST_INCR = 2'b01;
    localparam logic [LEN_W-1:0] AXI_LEN_SINGLE = 8'h00;

    // Map core byte enables to an AXI transfer size; odd patterns fall back to a full word.
    function automatic logic [SIZE_W-1:0] be_to_size(input logic [BE_W-1:0] be);
        logic [SIZE_W-1:0] size;
        case (be)
            4'b1111:                            size = 3'd2;
            4'b0011, 4'b1100:                   size = 3'd1;
            4'b0001, 4'b0010, 4'b0100, 4'b1000: size = 3'd0;
            default:                            size = 3'd2;
        endcase
        return size;
    endfunction

endpackage

// File: rtl/daccess_axi_bridge.sv
// Bridges the core's single-outstanding data-access port onto AXI3 single-beat reads and writes.
module daccess_axi_bridge
    import daccess_axi_pkg::*;
#(
    parameter logic [ID_W-1:0] RD_ID = 4'h0,
    parameter logic [ID_W-1:0] WR_ID = 4'h1
) (
    input  logic              cpu_clk,
    input  logic              cpu_rst,

    input  logic [BE_W-1:0]   daccess_ren,
    input  logic [BE_W-1:0]   daccess_wen,
    input  logic [ADDR_W-1:0] daccess_addr,
    input  logic [DATA_W-1:0] daccess_wdata,
    output logic              daccess_valid,
    output logic [DATA_W-1:0] daccess_rdata,
    output logic              daccess_wresp,
    output logic              bus_err,

    output logic [ID_W-1:0]   arid,
    output logic [ADDR_W-1:0] araddr,
    output logic [LEN_W-1:0]  arlen,
    output logic [SIZE_W-1:0] arsize,
    output logic [1:0]        arburst,
    output logic [1:0]        arlock,
    output logic [3:0]        arcache,
    output logic [2:0]        arprot,
    output logic              arvalid,
    input  logic              arready,

    input  logic [ID_W-1:0]   rid,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rlast,
    input  logic              rvalid,
    output logic              rready,

    output logic [ID_W-1:0]   awid,
    output logic [ADDR_W-1:0] awaddr,
    output logic [LEN_W-1:0]  awlen,
    output logic [SIZE_W-1:0] awsize,
    output logic [1:0]        awburst,
    output logic [1:0]        awlock,
    output logic [3:0]        awcache,
    output logic [2:0]        awprot,
    output logic              awvalid,
    input  logic              awready,

    output logic [ID_W-1:0]   wid,
    output logic [DATA_W-1:0] wdata,
    output logic [BE_W-1:0]   wstrb,
    output logic              wlast,
    output logic              wvalid,
    input  logic              wready,

    input  logic [ID_W-1:0]   bid,
    input  logic [1:0]        bresp,
    input  logic              bvalid,
    output logic              bready
);

    state_t              state;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [BE_W-1:0]     be_q;
    logic [SIZE_W-1:0]   size_q;
    logic                aw_done;
    logic                w_done;
    logic                aw_fire;
    logic                w_fire;

    // Response IDs and rlast carry nothing for a single-outstanding, single-beat master.
    logic                unused_resp_fields;
    assign unused_resp_fields = ^{rid, rlast, bid};

    assign aw_fire = awvalid & awready;
    assign w_fire  = wvalid & wready;

    // Address/data channels carry the request latched in IDLE; burst attributes are fixed.
    assign arid    = RD_ID;
    assign araddr  = addr_q;
    assign arlen   = AXI_LEN_SINGLE;
    assign arsize  = size_q;
    assign arburst = AXI_BURST_INCR;
    assign arlock  = 2'b00;
    assign arcache = 4'b0000;
    assign arprot  = 3'b000;

    assign awid    = WR_ID;
    assign awaddr  = addr_q;
    assign awlen   = AXI_LEN_SINGLE;
    assign awsize  = size_q;
    assign awburst = AXI_BURST_INCR;
    assign awlock  = 2'b00;
    assign awcache = 4'b0000;
    assign awprot  = 3'b000;

    assign wid     = WR_ID;
    assign wdata   = wdata_q;
    assign wstrb   = be_q;
    assign wlast   = 1'b1;

    // Transaction FSM with registered channel handshakes, request latches and completion pulses.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            state         <= IDLE;
            addr_q        <= '0;
            wdata_q       <= '0;
            be_q          <= '0;
            size_q        <= '0;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            arvalid       <= 1'b0;
            rready        <= 1'b0;
            awvalid       <= 1'b0;
            wvalid        <= 1'b0;
            bready        <= 1'b0;
            daccess_valid <= 1'b0;
            daccess_wresp <= 1'b0;
            daccess_rdata <= '0;
            bus_err       <= 1'b0;
        end else begin
            daccess_valid <= 1'b0;
            daccess_wresp <= 1'b0;
            case (state)
                IDLE: begin
                    // A write wins when both enables are presented together.
                    if (|daccess_wen) begin
                        addr_q  <= daccess_addr;
                        wdata_q <= daccess_wdata;
                        be_q    <= daccess_wen;
                        size_q  <= be_to_size(daccess_wen);
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        awvalid <= 1'b1;
                        wvalid  <= 1'b1;
                        state   <= WR_REQ;
                    end else if (|daccess_ren) begin
                        addr_q  <= daccess_addr;
                        be_q    <= daccess_ren;
                        size_q  <= be_to_size(daccess_ren);
                        arvalid <= 1'b1;
                        state   <= RD_ADDR;
                    end
                end
                RD_ADDR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (rvalid) begin
                        rready        <= 1'b0;
                        daccess_rdata <= rdata;
                        if (|rresp) begin
                            bus_err <= 1'b1;
                        end
                        daccess_valid <= 1'b1;
                        state         <= DONE;
                    end
                end
                WR_REQ: begin
                    // AW and W complete independently; leave once both have handshaken.
                    if (aw_fire) begin
                        awvalid <= 1'b0;
                        aw_done <= 1'b1;
                    end
                    if (w_fire) begin
                        wvalid <= 1'b0;
                        w_done <= 1'b1;
                    end
                    if ((aw_done | aw_fire) && (w_done | w_fire)) begin
                        bready <= 1'b1;
                        state  <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (bvalid) begin
                        bready <= 1'b0;
                        if (|bresp) begin
                            bus_err <= 1'b1;
                        end
                        daccess_wresp <= 1'b1;
                        state         <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_daccess_axi_bridge.sv
// Directed scoreboard bench for daccess_axi_bridge.
module tb_daccess_axi_bridge;

    logic        clk;
    logic        rst;
    logic [3:0]  daccess_ren;
    logic [3:0]  daccess_wen;
    logic [31:0] daccess_addr;
    logic [31:0] daccess_wdata;
    logic        daccess_valid;
    logic [31:0] daccess_rdata;
    logic        daccess_wresp;
    logic        bus_err;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [1:0]  awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    daccess_axi_bridge dut (
        .cpu_clk(clk), .cpu_rst(rst),
        .daccess_ren(daccess_ren), .daccess_wen(daccess_wen),
        .daccess_addr(daccess_addr), .daccess_wdata(daccess_wdata),
        .daccess_valid(daccess_valid), .daccess_rdata(daccess_rdata),
        .daccess_wresp(daccess_wresp), .bus_err(bus_err),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    typedef struct packed {
        logic        is_wr;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          ar_hs   = 0;
    logic [31:0] m_rdata = 32'h0;
    logic        m_err   = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_b(input string name, input logic act, input logic exp);
        chk(name, 32'(act), 32'(exp));
    endtask

    // Count every AR handshake the slave accepts.
    always @(posedge clk) begin
        if (arvalid && arready) ar_hs <= ar_hs + 1;
    end

    // Monitor: each completion pulse is checked against the oldest expected response.
    always @(negedge clk) begin
        if (!rst && (daccess_valid || daccess_wresp)) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_unexpected: got pulse valid=%0b wresp=%0b required none", daccess_valid, daccess_wresp);
            end else begin
                mon_e = sb.pop_front();
                chk("sb_kind", 32'({daccess_wresp, daccess_valid}), mon_e.is_wr ? 32'd2 : 32'd1);
                chk("sb_rdata", daccess_rdata, mon_e.rdata);
                chk_b("sb_bus_err", bus_err, mon_e.err);
            end
        end
    end

    task automatic do_read(input logic [31:0] addr, input logic [3:0] be, input logic [2:0] exp_size,
                           input int ar_wait, input int r_wait, input logic [31:0] data, input logic [1:0] resp);
        int ar0;
        ar0 = ar_hs;
        m_rdata = data;
        m_err   = m_err | (resp != 2'b00);
        sb.push_back('{is_wr: 1'b0, rdata: data, err: m_err});
        daccess_ren  = be;
        daccess_addr = addr;
        arready      = 1'b0;
        @(posedge clk); #1;
        chk_b("rd_arvalid", arvalid, 1'b1);
        chk("rd_arsize", 32'(arsize), 32'(exp_size));
        chk("rd_araddr", araddr, addr);
        chk("rd_arconst", 32'({arid, arlen, arburst, arlock, arcache, arprot}), 32'({4'h0, 8'h00, 2'b01, 2'b00, 4'h0, 3'h0}));
        arready = (ar_wait == 0);
        for (int i = 0; i < ar_wait; i++) begin
            @(posedge clk); #1;
            chk_b("rd_arvalid_hold", arvalid, 1'b1);
            chk("rd_araddr_hold", araddr, addr);
            arready = (i == ar_wait - 1);
        end
        @(posedge clk); #1;
        arready = 1'b0;
        chk_b("rd_arvalid_drop", arvalid, 1'b0);
        chk_b("rd_rready", rready, 1'b1);
        rdata  = data;
        rresp  = resp;
        rvalid = (r_wait == 0);
        for (int i = 0; i < r_wait; i++) begin
            @(posedge clk); #1;
            chk_b("rd_rready_hold", rready, 1'b1);
            rvalid = (i == r_wait - 1);
        end
        @(posedge clk); #1;
        rvalid = 1'b0;
        chk_b("rd_done_valid", daccess_valid, 1'b1);
        chk_b("rd_done_rready", rready, 1'b0);
        // Request is still held through DONE; it drops at the edge that ends DONE.
        @(posedge clk); #1;
        daccess_ren = 4'h0;
        chk_b("rd_valid_pulse", daccess_valid, 1'b0);
        chk_b("rd_no_reissue", arvalid, 1'b0);
        @(posedge clk); #1;
        chk_b("rd_idle_arvalid", arvalid, 1'b0);
        chk("rd_ar_count", 32'(ar_hs - ar0), 32'd1);
        chk("rd_rdata_hold", daccess_rdata, data);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] data,
                            input logic [2:0] exp_size, input int aw_wait, input int w_wait,
                            input int b_wait, input logic [1:0] resp, input logic [3:0] ren);
        int   ar0;
        int   k;
        logic aw_got;
        logic w_got;
        ar0    = ar_hs;
        m_err  = m_err | (resp != 2'b00);
        sb.push_back('{is_wr: 1'b1, rdata: m_rdata, err: m_err});
        daccess_wen   = be;
        daccess_ren   = ren;
        daccess_addr  = addr;
        daccess_wdata = data;
        awready = 1'b0;
        wready  = 1'b0;
        @(posedge clk); #1;
        chk("wr_awsize", 32'(awsize), 32'(exp_size));
        chk("wr_wstrb", 32'(wstrb), 32'(be));
        chk("wr_awaddr", awaddr, addr);
        chk("wr_wdata", wdata, data);
        chk("wr_ids", 32'({awid, wid, wlast}), 32'({4'h1, 4'h1, 1'b1}));
        aw_got = 1'b0;
        w_got  = 1'b0;
        k      = 0;
        while (!(aw_got && w_got) && k < 40) begin
            chk_b("wr_awvalid", awvalid, !aw_got);
            chk_b("wr_wvalid", wvalid, !w_got);
            chk_b("wr_arvalid_quiet", arvalid, 1'b0);
            awready = (k == aw_wait);
            wready  = (k == w_wait);
            @(posedge clk);
            if (k == aw_wait) aw_got = 1'b1;
            if (k == w_wait)  w_got  = 1'b1;
            #1;
            k++;
        end
        awready = 1'b0;
        wready  = 1'b0;
        if (k >= 40) chk("wr_handshake_timeout", 32'(k), 32'd0);
        chk_b("wr_awvalid_drop", awvalid, 1'b0);
        chk_b("wr_wvalid_drop", wvalid, 1'b0);
        chk_b("wr_bready", bready, 1'b1);
        bresp  = resp;
        bvalid = (b_wait == 0);
        for (int i = 0; i < b_wait; i++) begin
            @(posedge clk); #1;
            chk_b("wr_bready_hold", bready, 1'b1);
            bvalid = (i == b_wait - 1);
        end
        @(posedge clk); #1;
        bvalid = 1'b0;
        chk_b("wr_done_wresp", daccess_wresp, 1'b1);
        chk_b("wr_done_bready", bready, 1'b0);
        daccess_wen = 4'h0;
        daccess_ren = 4'h0;
        @(posedge clk); #1;
        chk_b("wr_wresp_pulse", daccess_wresp, 1'b0);
        chk_b("wr_arvalid_never", arvalid, 1'b0);
        chk("wr_ar_count", 32'(ar_hs - ar0), 32'd0);
    endtask

    // Overall time bound.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        daccess_ren = 4'h0; daccess_wen = 4'h0; daccess_addr = 32'h0; daccess_wdata = 32'h0;
        arready = 1'b0; awready = 1'b0; wready = 1'b0;
        rid = 4'h0; rdata = 32'h0; rresp = 2'b00; rlast = 1'b1; rvalid = 1'b0;
        bid = 4'h1; bresp = 2'b00; bvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ctrl", 32'({arvalid, rready, awvalid, wvalid, bready, daccess_valid, daccess_wresp, bus_err}), 32'd0);
        chk("rst_rdata", daccess_rdata, 32'h0);
        chk("rst_addr", araddr, 32'h0);
        chk("rst_wstrb_wdata", 32'(wstrb) | wdata, 32'h0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        do_read(32'h1C00_0100, 4'b1111, 3'd2, 0, 0, 32'hDEAD_BEEF, 2'b00);
        do_write(32'h1C00_0201, 4'b0010, 32'h0000_AB00, 3'd0, 3, 0, 0, 2'b00, 4'h0);
        do_write(32'h1C00_0300, 4'b1111, 32'h1234_5678, 3'd2, 0, 0, 0, 2'b10, 4'h0);
        do_read(32'h1C00_0110, 4'b1000, 3'd0, 1, 2, 32'hCAFE_F00D, 2'b00);
        do_write(32'h1C00_0400, 4'b1100, 32'hAAAA_0000, 3'd1, 0, 0, 1, 2'b00, 4'b1111);
        do_write(32'h1C00_0404, 4'b0101, 32'h5555_5555, 3'd2, 0, 2, 0, 2'b00, 4'h0);
        chk_b("bus_err_sticky", bus_err, 1'b1);

        // Reset while waiting for read data.
        daccess_ren  = 4'b0011;
        daccess_addr = 32'h1C00_0600;
        arready      = 1'b1;
        @(posedge clk); #1;
        chk_b("rr_arvalid", arvalid, 1'b1);
        @(posedge clk); #1;
        arready = 1'b0;
        chk_b("rr_rready", rready, 1'b1);
        rst = 1'b1;
        #1;
        chk("rr_ctrl", 32'({arvalid, rready, awvalid, wvalid, bready, daccess_valid, daccess_wresp, bus_err}), 32'd0);
        chk("rr_rdata", daccess_rdata, 32'h0);
        chk("rr_addr", araddr, 32'h0);
        m_err   = 1'b0;
        m_rdata = 32'h0;
        daccess_ren = 4'h0;
        @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        do_read(32'h1C00_0600, 4'b0011, 3'd1, 2, 0, 32'h0BAD_F00D, 2'b00);
        do_read(32'h1C00_0700, 4'b0110, 3'd2, 0, 1, 32'h55AA_55AA, 2'b01);
        chk_b("rd_err_sticky", bus_err, 1'b1);

        repeat (2) @(posedge clk);
        #1;
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
